// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative 32-bit multiply/divide unit owning the HI/LO
//               registers (shift-add multiply, restoring divide, MTHI/MTLO).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;        // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [31:0] r_opnd;       // multiplicand or divisor magnitude
    logic [31:0] r_dividend;
    logic        r_is_div;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic        r_div0;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_signed;
    logic        w_is_div_op;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;
    logic [32:0] w_trial;
    logic [63:0] w_mul_nxt;
    logic [63:0] w_div_nxt;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_accept    = start && (r_state != S_CALC) &&
                         (MDUOp >= OP_MULT) && (MDUOp <= OP_MTLO);
    assign w_signed    = (MDUOp == OP_MULT) || (MDUOp == OP_DIV);
    assign w_is_div_op = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign w_abs_a     = (w_signed && A[31]) ? -A : A;
    assign w_abs_b     = (w_signed && B[31]) ? -B : B;

    assign w_sum       = {1'b0, r_acc[63:32]} + {1'b0, r_opnd};
    assign w_mul_nxt   = r_acc[0] ? {w_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

    // The partial remainder after the shift can need 33 bits for unsigned divisors.
    assign w_trial     = r_acc[63:31] - {1'b0, r_opnd};
    assign w_div_nxt   = w_trial[32] ? {r_acc[62:0], 1'b0}
                                     : {w_trial[31:0], r_acc[30:0], 1'b1};
    assign w_acc_nxt   = r_is_div ? w_div_nxt : w_mul_nxt;

    assign w_prod      = r_neg_lo ? -w_acc_nxt : w_acc_nxt;
    assign w_quot      = r_neg_lo ? -w_acc_nxt[31:0]  : w_acc_nxt[31:0];
    assign w_rem       = r_neg_hi ? -w_acc_nxt[63:32] : w_acc_nxt[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_dividend <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div0     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        case (MDUOp)
                            OP_MTHI: r_hi <= A;
                            OP_MTLO: r_lo <= A;
                            default: begin
                                r_state    <= S_CALC;
                                r_busy     <= 1'b1;
                                r_cnt      <= 6'd0;
                                r_is_div   <= w_is_div_op;
                                r_opnd     <= w_is_div_op ? w_abs_b : w_abs_a;
                                r_acc      <= {32'd0, (w_is_div_op ? w_abs_a : w_abs_b)};
                                r_neg_lo   <= w_signed && (A[31] ^ B[31]);
                                r_neg_hi   <= w_signed && A[31];
                                r_div0     <= (B == 32'd0);
                                r_dividend <= A;
                            end
                        endcase
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        if (!r_is_div) begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end else if (r_div0) begin
                            r_hi <= r_dividend;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed scoreboard bench for mdu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    mdu_iter dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .MDUOp (MDUOp),
        .A     (A),
        .B     (B),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference results as {HI, LO}
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        model = 64'd0;
        sa = a;
        sb = b;
        case (op)
            3'd1: model = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            3'd2: model = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0)
                    model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    model = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    model = {r, q};
                end
            end
            3'd4: model = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: model = 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        MDUOp = 3'd0;
        if (op inside {[3'd1:3'd4]})
            exp_q.push_back(model(op, a, b));
    endtask

    // Waits for done after an accept edge; optionally pulses an MTLO mid-calc.
    task automatic wait_done(input string tag, input int inj_cyc, input logic [31:0] inj_a,
                             input bit chain);
        int          cyc = 0;
        int          bc  = 0;
        logic [63:0] pre = {HI, LO};
        while (!done && cyc < 100) begin
            if (busy) bc++;
            if (cyc == 20) check({tag, " hold"}, {HI, LO}, pre);
            if (cyc == inj_cyc) begin
                start = 1'b1;
                MDUOp = 3'd6;
                A     = inj_a;
            end
            tick();
            start = 1'b0;
            MDUOp = 3'd0;
            cyc++;
        end
        check({tag, " latency"}, cyc, 32);
        check({tag, " busy_cycles"}, bc, 32);
        check({tag, " busy_at_done"}, busy, 1'b0);
        if (exp_q.size() == 0)
            check({tag, " scoreboard_empty"}, 1, 0);
        else
            check({tag, " result"}, {HI, LO}, exp_q.pop_front());
        if (!chain) begin
            tick();
            check({tag, " done_pulse"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] saved;
        int          dcnt;

        rst   = 1'b1;
        start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_flags", {busy, done}, 2'b00);

        start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", -1, 32'd0, 1'b0);
        check("multu_max_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);

        start_op(3'd1, -32'sd3, 32'd5);
        wait_done("mult_neg", -1, 32'd0, 1'b0);
        check("mult_neg_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);

        start_op(3'd3, -32'sd7, 32'd2);
        wait_done("div_neg_a", -1, 32'd0, 1'b0);
        check("div_neg_a_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        start_op(3'd3, 32'd7, -32'sd2);
        wait_done("div_neg_b", -1, 32'd0, 1'b0);
        check("div_neg_b_const", {HI, LO}, 64'h0000_0001_FFFF_FFFD);

        start_op(3'd4, 32'h1234_5678, 32'd0);
        wait_done("divu_zero", -1, 32'd0, 1'b0);

        start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", -1, 32'd0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            start_op(3'(1 + (i % 4)), $urandom, $urandom_range(1, 32'h0001_FFFF));
            wait_done("random_op", -1, 32'd0, 1'b0);
        end

        // MTHI / MTLO
        saved = LO;
        start_op(3'd5, 32'hCAFE_BABE, 32'd0);
        check("mthi_hi", HI, 32'hCAFE_BABE);
        check("mthi_lo_kept", LO, saved);
        check("mthi_flags", {busy, done}, 2'b00);
        tick();
        check("mthi_flags_next", {busy, done}, 2'b00);
        start_op(3'd6, 32'h1357_9BDF, 32'd0);
        check("mtlo", {HI, LO}, 64'hCAFE_BABE_1357_9BDF);

        // Ignored opcodes
        start_op(3'd7, 32'hDEAD_BEEF, 32'd1);
        start_op(3'd0, 32'hDEAD_BEEF, 32'd1);
        check("ignored_op", {HI, LO, busy, done}, {64'hCAFE_BABE_1357_9BDF, 2'b00});

        // MTLO issued mid-calculation must be dropped
        start_op(3'd1, 32'd123456, -32'sd789);
        wait_done("mult_mtlo_ignored", 10, 32'h5555_AAAA, 1'b0);

        // Back-to-back: second request accepted in the DONE cycle
        start_op(3'd2, 32'h0000_FFFF, 32'h0001_0001);
        wait_done("b2b_first", -1, 32'd0, 1'b1);
        start_op(3'd4, 32'hFFFF_FFF0, 32'd7);
        wait_done("b2b_second", -1, 32'd0, 1'b0);

        // Reset during calculation
        start_op(3'd4, 32'h8765_4321, 32'd13);
        void'(exp_q.pop_back());
        for (int i = 0; i < 15; i++) tick();
        check("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midcalc_reset", {HI, LO, busy, done}, 66'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        check("no_done_after_reset", dcnt, 0);

        start_op(3'd2, 32'hABCD_0123, 32'h0F0F_F0F0);
        wait_done("multu_after_reset", -1, 32'd0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
